// File: rtl/mul_lk_pipe_pkg.sv
// Shared types and per-lane arithmetic for the L(x^k) codeword multiplier pipeline.
// Latency: none. The package holds combinational helper functions only.
// Backpressure: not applicable.
package mul_lk_pipe_pkg;

    // Redundancy degree. A codeword carries 8+D bits, and bit 0 is the lowest degree.
    localparam int D       = 2;
    // Number of codewords in each beat. One MixColumns column is four codewords.
    localparam int N_LANES = 4;
    localparam int W       = 8 + D;      // codeword width
    localparam int PW      = 15 + D;     // width of the unreduced product
    localparam int OV_W    = PW - W;     // overflow columns above the codeword (7)
    localparam int SEL_W   = 3;          // width of the power select k

    typedef logic [W-1:0]                state_t;
    typedef logic [D-1:0]                red_poly_t;
    typedef state_t    [N_LANES-1:0]     lane_state_t;
    typedef red_poly_t [N_LANES-1:0]     lane_r_t;
    typedef logic [7:0][7:0]             mm_matrix_t;    // row k = multiplier L(x^k)
    typedef logic [OV_W+D-1:0][7:0]      mc_m_matrix_t;  // row j = reduction of {r,ov} bit j

    // State held between the two stages for one lane.
    typedef struct packed {
        state_t          low;   // product columns 0..W-1
        logic [OV_W-1:0] ov;    // product columns W..PW-1
        red_poly_t       r;     // refresh bits captured with the beat
    } s1_lane_t;

    typedef s1_lane_t [N_LANES-1:0] lane_s1_t;

    // Stage 1: carry-less product of the codeword with the selected multiplier row.
    // The result is split into the part kept in place and the overflow columns.
    function automatic s1_lane_t lk_stage1(input state_t din, input logic [7:0] row,
                                           input red_poly_t r);
        logic [PW-1:0] acc;
        s1_lane_t      s;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (({{OV_W{1'b0}}, din} << i) & {PW{row[i]}});
        end
        s.low = acc[W-1:0];
        s.ov  = acc[PW-1:W];
        s.r   = r;
        return s;
    endfunction

    // Stage 2: fold the overflow columns and the refresh bits back into the low byte
    // through the encoder matrix. The refresh bits also replace the redundancy
    // positions, so the decoded value does not change while the mask is refreshed.
    function automatic state_t lk_stage2(input s1_lane_t s, input mc_m_matrix_t b);
        logic [OV_W+D-1:0] v;
        logic [7:0]        red;
        v   = {s.r, s.ov};
        red = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < OV_W + D; j++) begin
                red[i] = red[i] ^ (v[j] & b[j][i]);
            end
        end
        return s.low ^ {s.r, red};
    endfunction

endpackage

// File: rtl/mul_lk_pipe_if.sv
// Beat-level handshake bundle of the multiplier: input beat, output beat and their handshakes.
// Latency: none. The interface holds wires only.
// Backpressure: in_ready and out_ready follow the usual valid/ready rules.
interface mul_lk_pipe_if;
    import mul_lk_pipe_pkg::*;

    logic                in_valid;
    logic                in_ready;
    lane_state_t         in_data;
    logic [SEL_W-1:0]    in_sel;
    lane_r_t             in_r;
    logic                out_valid;
    logic                out_ready;
    lane_state_t         out_data;

    // The producer/consumer side. It drives beats in and takes results out.
    modport master (
        output in_valid, in_data, in_sel, in_r, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The multiplier side.
    modport slave (
        input  in_valid, in_data, in_sel, in_r, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/mul_lk_pipe_lane.sv
// One codeword lane. It holds the combinational stage-1 product split and the stage-2 fold.
// Latency: 0. The pipeline registers are kept in mul_lk_pipe.
// Backpressure: none. The parent decides when each stage is loaded.
module mul_lk_lane
    import mul_lk_pipe_pkg::*;
(
    input  state_t       i_dat,   // codeword arriving with the beat
    input  logic [7:0]   i_row,   // multiplier row L[k]
    input  red_poly_t    i_r,     // fresh refresh bits for this lane
    input  s1_lane_t     i_s1,    // registered stage-1 state of this lane
    input  mc_m_matrix_t i_b,     // systematic encoder matrix
    output s1_lane_t     o_s1,    // next stage-1 state
    output state_t       o_out    // reduced and refreshed codeword
);

    assign o_s1  = lk_stage1(i_dat, i_row, i_r);
    assign o_out = lk_stage2(i_s1, i_b);

endmodule

// File: rtl/mul_lk_pipe.sv
// Two-stage, N_LANES-wide multiplier of CLM codewords by L(x^k), with reduction and mask refresh.
// Latency: 2 cycles from accept to out_valid. Throughput is 1 beat per cycle. MUL_LK_PIPE_FLUSH_EN adds the flush port.
// Backpressure: stage 2 holds while it is blocked, and in_ready is derived combinationally from out_ready. There is no skid buffer.
module mul_lk_pipe
    import mul_lk_pipe_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
`ifdef MUL_LK_PIPE_FLUSH_EN
    input  logic         flush,
`endif
    mul_lk_pipe_if.slave bus,
    input  mm_matrix_t   L,
    input  mc_m_matrix_t B_ext_MC
);

    logic        w_flush;
    logic        w_s2_free;
    logic        w_in_rdy;
    logic [7:0]  w_row;
    lane_s1_t    w_s1_nxt;
    lane_state_t w_s2_nxt;

    logic        r_s1_vld;
    logic        r_s2_vld;
    lane_s1_t    r_s1;
    lane_state_t r_s2;

`ifdef MUL_LK_PIPE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Stage 2 can load when it is empty or when its beat leaves in this cycle.
    assign w_s2_free = !r_s2_vld || bus.out_ready;
    // Stage 1 can load when it is empty or when it hands its beat to stage 2. A flush blocks new beats.
    assign w_in_rdy  = !w_flush && (!r_s1_vld || w_s2_free);
    assign w_row     = L[bus.in_sel];

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        mul_lk_lane u_lane (
            .i_dat (bus.in_data[g]),
            .i_row (w_row),
            .i_r   (bus.in_r[g]),
            .i_s1  (r_s1[g]),
            .i_b   (B_ext_MC),
            .o_s1  (w_s1_nxt[g]),
            .o_out (w_s2_nxt[g])
        );
    end

    // Stage 1 register. It captures data, sel and refresh with each accepted beat, and holds while blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1     <= '0;
        end else if (w_flush) begin
            r_s1_vld <= 1'b0;
        end else if (w_in_rdy) begin
            r_s1_vld <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1 <= w_s1_nxt;
            end
        end
    end

    // Stage 2 register. It holds the output beat while it is blocked, and keeps the last data when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld <= 1'b0;
            r_s2     <= '0;
        end else if (w_flush) begin
            r_s2_vld <= 1'b0;
        end else if (w_s2_free) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2 <= w_s2_nxt;
            end
        end
    end

    assign bus.in_ready  = w_in_rdy;
    assign bus.out_valid = r_s2_vld;
    assign bus.out_data  = r_s2;

endmodule

// File: tb/tb_mul_lk_pipe.sv
// Randomised scoreboard bench for mul_lk_pipe. It uses a GF(2^8)/0x11B polynomial reference model.
// Latency: the bench checks that results appear 2 cycles after accept when the pipeline is not stalled.
// Backpressure: the bench drives random and directed out_ready stalls, a reset during traffic and an optional flush.
module tb_mul_lk_pipe;
    import mul_lk_pipe_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    mm_matrix_t   L;
    mc_m_matrix_t B;

    lane_state_t  sb[$];
    int           pop_cyc[$];
    lane_state_t  mon_exp;
    int           cyc    = 0;
    int           checks = 0;
    int           errors = 0;
    int           n_acc  = 0;
    bit           rnd_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_lk_pipe_if bus();

    mul_lk_pipe dut (
        .clk      (clk),
        .rst      (rst),
`ifdef MUL_LK_PIPE_FLUSH_EN
        .flush    (flush),
`endif
        .bus      (bus),
        .L        (L),
        .B_ext_MC (B)
    );

    // Reduces a polynomial of up to degree PW-1 modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] pmod(input logic [PW-1:0] p);
        logic [PW-1:0] q;
        q = p;
        for (int b = PW - 1; b >= 8; b--) begin
            if (q[b]) q = q ^ (PW'(17'h11B) << (b - 8));
        end
        return q[7:0];
    endfunction

    // Decodes a codeword to the field element it represents: the codeword polynomial modulo P.
    function automatic logic [7:0] dec(input state_t c);
        return pmod(PW'(c));
    endfunction

    // Reference result for one lane. The redundancy bits are the product's columns 8.. XOR r.
    // The low byte is whatever value makes the codeword decode to (in * m) mod P.
    function automatic state_t model_lane(input state_t din, input logic [7:0] m, input red_poly_t r);
        logic [PW-1:0] p;
        red_poly_t     hi;
        logic [7:0]    lo;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ (PW'(din) << i);
        end
        hi = p[8 +: D] ^ r;
        lo = pmod(p) ^ pmod(PW'(hi) << 8);
        return {hi, lo};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Records each accepted beat. A reset or flush drops everything that is in flight.
    always @(negedge clk) begin
        #1;
        if (rst || flush) begin
            sb.delete();
        end else if (bus.in_valid && bus.in_ready) begin
            lane_state_t e;
            for (int g = 0; g < N_LANES; g++)
                e[g] = model_lane(bus.in_data[g], L[bus.in_sel], bus.in_r[g]);
            sb.push_back(e);
            n_acc++;
        end
    end

    // Checks every output transfer against the oldest expected result.
    always @(negedge clk) begin
        #2;
        if (!rst && !flush && bus.out_valid && bus.out_ready) begin
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %h expected no beat", bus.out_data);
            end else begin
                mon_exp = sb.pop_front();
                chk("out_data", 64'(bus.out_data), 64'(mon_exp));
            end
        end
    end

    // Offers one beat and holds it until it is accepted. Starts and ends on a negedge.
    task automatic send(input logic [2:0] s, input lane_state_t dat, input lane_r_t r);
        bit acc;
        bus.in_valid = 1'b1;
        bus.in_sel   = s;
        bus.in_data  = dat;
        bus.in_r     = r;
        for (int t = 0; t < 100; t++) begin
            #1;
            acc = bus.in_ready;
            @(negedge clk);
            if (acc) begin
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready=0 for 100 cycles expected accept");
    endtask

    task automatic rnd(output lane_state_t d, output lane_r_t r);
        for (int g = 0; g < N_LANES; g++) begin
            d[g] = state_t'($urandom);
            r[g] = red_poly_t'($urandom);
        end
    endtask

    // Sends one beat into an empty pipeline with out_ready=1, checks the exact 2-cycle latency and returns the result.
    task automatic direct(input logic [2:0] s, input lane_state_t dat, input lane_r_t r,
                          output lane_state_t got);
        send(s, dat, r);
        #1;
        chk("lat1_vld", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        #1;
        chk("lat2_vld", 64'(bus.out_valid), 64'(1));
        got = bus.out_data;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && sb.size() != 0; t++) @(negedge clk);
        chk("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    lane_state_t d, got;
    lane_r_t     r;
    int          base;

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sel = '0;
        bus.in_data = '0;
        bus.in_r = '0;
        bus.out_ready = 1'b1;
        L[0] = 8'h01; L[1] = 8'h02; L[2] = 8'h03; L[3] = 8'h04;
        L[4] = 8'h08; L[5] = 8'h10; L[6] = 8'h1B; L[7] = 8'h57;
        for (int j = 0; j < OV_W; j++) B[j] = pmod(PW'(1) << (8 + D + j));
        for (int m = 0; m < D; m++) B[OV_W + m] = pmod(PW'(1) << (8 + m));

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);

        // Identity multiplier with no refresh.
        for (int g = 0; g < N_LANES; g++) d[g] = 10'h057;
        r = '0;
        direct(3'd0, d, r, got);
        chk("ident_57", 64'(dec(got[0])), 64'(8'h57));

        // xtime, with random refresh bits.
        rnd(d, r);
        d[0] = 10'h080;
        d[1] = 10'h057;
        direct(3'd1, d, r, got);
        chk("xtime_80", 64'(dec(got[0])), 64'(8'h1B));
        chk("xtime_57", 64'(dec(got[1])), 64'(8'hAE));
        chk("xtime_80_rbits", 64'(got[0][W-1:8]), 64'(r[0] ^ 2'b01));
        rnd(d, r);
        d[0] = 10'h057;
        direct(3'd3, d, r, got);
        chk("sel3_57", 64'(dec(got[0])), 64'(8'h47));
        chk("sel3_57_rbits", 64'(got[0][W-1:8]), 64'(r[0] ^ 2'b01));

        // 16 back-to-back beats.
        pop_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            rnd(d, r);
            send(3'($urandom), d, r);
        end
        drain();
        chk("b2b_count", 64'(pop_cyc.size()), 64'(16));
        if (pop_cyc.size() == 16)
            chk("b2b_consecutive", 64'(pop_cyc[15] - pop_cyc[0]), 64'(15));

        // Backpressure: 3 beats offered while out_ready is held low.
        base = n_acc;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    rnd(d, r);
                    send(3'($urandom), d, r);
                end
            end
            begin
                repeat (3) @(negedge clk);
                #3;
                chk("bp_accepted", 64'(n_acc - base), 64'(2));
                chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
                chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
                repeat (2) @(negedge clk);
                #3;
                chk("bp_accepted_late", 64'(n_acc - base), 64'(2));
                if (sb.size() != 0)
                    chk("bp_hold_data", 64'(bus.out_data), 64'(sb[0]));
                @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset while 2 beats are in flight.
        rnd(d, r);
        send(3'd2, d, r);
        rnd(d, r);
        send(3'd5, d, r);
        rst = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst_out_data", 64'(bus.out_data), 64'(0));
        chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("midrst_no_stale", 64'(bus.out_valid), 64'(0));
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            rnd(d, r);
            send(3'($urandom), d, r);
        end
        drain();

`ifdef MUL_LK_PIPE_FLUSH_EN
        // Flush of a full pipeline while out_ready is low.
        bus.out_ready = 1'b0;
        rnd(d, r);
        send(3'd1, d, r);
        rnd(d, r);
        send(3'd4, d, r);
        flush = 1'b1;
        rnd(d, r);
        bus.in_data = d;
        bus.in_r = r;
        bus.in_valid = 1'b1;
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 64'(0));
        chk("flush_full", 64'(bus.out_valid), 64'(1));
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("flush_empty", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        rnd(d, r);
        direct(3'd6, d, r, got);
`endif

        // Random traffic with random stalls.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                    rnd(d, r);
                    send(3'($urandom), d, r);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
